// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Accepts one ALU command at a time, drives it into an external ALU+shifter
// datapath through registered alu_* outputs, waits LATENCY cycles for the
// datapath to settle, captures the result and presents it on a valid/ready
// response channel until the consumer takes it.
//
// Parameters:
//   LATENCY   register stages between alu_* and a stable alu_o/alu_cout (1..4)
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_a/b/s/cin/h       command operands, function select, carry-in, shift
//   alu_a/b/s/cin/h       registered drive into the datapath
//   alu_o, alu_cout       datapath result and carry-out
//   rsp_valid/rsp_ready   response handshake
//   rsp_o, rsp_cout       captured result and carry-out
//   rsp_zero              captured result == 0 (only with ALU_CMD_SEQ_ZERO_FLAG_EN)
//   busy                  high whenever not idle
//   ops_done              wrapping count of completed operations
//
// Build option: define ALU_CMD_SEQ_ZERO_FLAG_EN to add the rsp_zero output.

module alu_cmd_sequencer #(
    parameter int unsigned LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_s,
    input  logic       cmd_cin,
    input  logic [1:0] cmd_h,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    output logic       alu_cin,
    output logic [1:0] alu_h,
    input  logic [3:0] alu_o,
    input  logic       alu_cout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_o,
    output logic       rsp_cout,
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
    output logic       rsp_zero,
`endif
    output logic       busy,
    output logic [7:0] ops_done
);

    localparam logic [2:0] LatCnt = 3'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StCapture, StResp} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_cmd;
    logic       capture;
    logic       rsp_hs;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_cmd = 1'b0;
        capture  = 1'b0;
        rsp_hs   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    cnt_d    = LatCnt;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // Counter holds the number of WAIT cycles still to spend,
                // including the current one.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands only change on accept, so the datapath sees stable inputs
    // for the whole operation and keeps the last command while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a   <= 4'h0;
            alu_b   <= 4'h0;
            alu_s   <= 3'h0;
            alu_cin <= 1'b0;
            alu_h   <= 2'h0;
        end else if (load_cmd) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_s   <= cmd_s;
            alu_cin <= cmd_cin;
            alu_h   <= cmd_h;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_o    <= 4'h0;
            rsp_cout <= 1'b0;
        end else if (capture) begin
            rsp_o    <= alu_o;
            rsp_cout <= alu_cout;
        end
    end

`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_zero <= 1'b0;
        end else if (capture) begin
            rsp_zero <= (alu_o == 4'h0);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_done <= 8'd0;
        end else if (rsp_hs) begin
            ops_done <= ops_done + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with LATENCY=1 and a one-stage
// registered adder standing in for the ALU datapath (O = A + B + Cin).

module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_s;
    logic       cmd_cin;
    logic [1:0] cmd_h;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic       alu_cin;
    logic [1:0] alu_h;
    logic [3:0] alu_o;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_o;
    logic       rsp_cout;
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
    logic       rsp_zero;
`endif
    logic       busy;
    logic [7:0] ops_done;

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.LATENCY(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_s     (cmd_s),
        .cmd_cin   (cmd_cin),
        .cmd_h     (cmd_h),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_cin   (alu_cin),
        .alu_h     (alu_h),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_o     (rsp_o),
        .rsp_cout  (rsp_cout),
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
        .rsp_zero  (rsp_zero),
`endif
        .busy      (busy),
        .ops_done  (ops_done)
    );

    // ALU stub: one register stage, F = A + B + Cin.
    logic [4:0] f_q;
    always_ff @(posedge clk) begin
        f_q <= {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    end
    assign alu_o    = f_q[3:0];
    assign alu_cout = f_q[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         nacc;
        int         nhs;
        int         prev_c;
        int         bad_space;
        int         bad_rsp;
        bit         chk255;
        logic [4:0] exp_sum;
        logic [4:0] exp_q[$];

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_s     = 3'h0;
        cmd_cin   = 1'b0;
        cmd_h     = 2'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_o", rsp_o, 0);
        check("rst_rsp_cout", rsp_cout, 0);
        check("rst_busy", busy, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_alu", {alu_a, alu_b, alu_s, alu_cin, alu_h}, 0);
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
        check("rst_rsp_zero", rsp_zero, 0);
`endif
        tick();

        // 3 + 5 + 0, rsp_ready already high before rsp_valid
        cmd_valid = 1'b1;
        cmd_a     = 4'h3;
        cmd_b     = 4'h5;
        cmd_s     = 3'h5;
        cmd_cin   = 1'b0;
        cmd_h     = 2'h2;
        rsp_ready = 1'b1;
        tick();
        check("t1_cmd_ready", cmd_ready, 0);
        check("t1_busy", busy, 1);
        check("t1_alu", {alu_a, alu_b, alu_s, alu_cin, alu_h}, {4'h3, 4'h5, 3'h5, 1'b0, 2'h2});
        check("t1_rsp_valid_wait", rsp_valid, 0);
        cmd_valid = 1'b0;
        cmd_a     = 4'hC;
        tick();
        check("t1_rsp_valid_capt", rsp_valid, 0);
        check("t1_alu_a_hold", alu_a, 4'h3);
        tick();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_o", rsp_o, 4'h8);
        check("t1_rsp_cout", rsp_cout, 0);
        tick();
        check("t1_rsp_valid_done", rsp_valid, 0);
        check("t1_cmd_ready_done", cmd_ready, 1);
        check("t1_ops_done", ops_done, 1);
        check("t1_alu_a_idle", alu_a, 4'h3);

        // F + 1 + 1 with back-pressure; cmd_valid in RESP must be ignored
        cmd_valid = 1'b1;
        cmd_a     = 4'hF;
        cmd_b     = 4'h1;
        cmd_cin   = 1'b1;
        rsp_ready = 1'b0;
        tick();
        check("t2_cmd_ready_acc", cmd_ready, 0);
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_rsp_valid", rsp_valid, 1);
            check("t2_rsp_o", rsp_o, 4'h1);
            check("t2_rsp_cout", rsp_cout, 1);
            check("t2_cmd_ready", cmd_ready, 0);
            cmd_valid = 1'b1;
            cmd_a     = 4'h7;
            tick();
        end
        check("t2_rsp_valid_hold", rsp_valid, 1);
        check("t2_rsp_o_hold", rsp_o, 4'h1);
        check("t2_alu_a_hold", alu_a, 4'hF);
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        tick();
        check("t2_cmd_ready_done", cmd_ready, 1);
        check("t2_rsp_valid_done", rsp_valid, 0);
        check("t2_ops_done", ops_done, 2);

        // Reset during WAIT discards the command
        cmd_valid = 1'b1;
        cmd_a     = 4'h2;
        cmd_b     = 4'h2;
        cmd_cin   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("t3_busy_wait", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("t3_rst_rsp_valid", rsp_valid, 0);
        check("t3_rst_alu", {alu_a, alu_b, alu_s, alu_cin, alu_h}, 0);
        check("t3_rst_busy", busy, 0);
        check("t3_rst_ops_done", ops_done, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_no_rsp", rsp_valid, 0);
        end
        check("t3_cmd_ready", cmd_ready, 1);
        check("t3_ops_done", ops_done, 0);

        // 256 back-to-back commands with cmd_valid held high
        nacc      = 0;
        nhs       = 0;
        prev_c    = -1;
        bad_space = 0;
        bad_rsp   = 0;
        chk255    = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 1030; c++) begin
            cmd_valid = (nacc < 256);
            cmd_a     = c[3:0];
            cmd_b     = c[7:4];
            cmd_cin   = c[0];
            if (cmd_valid && cmd_ready) begin
                if (prev_c >= 0 && (c - prev_c) != 4) bad_space++;
                prev_c = c;
                nacc++;
                exp_sum = {1'b0, cmd_a} + {1'b0, cmd_b} + {4'b0, cmd_cin};
                exp_q.push_back(exp_sum);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    bad_rsp++;
                end else begin
                    exp_sum = exp_q.pop_front();
                    if ({rsp_cout, rsp_o} !== exp_sum) bad_rsp++;
                end
                nhs++;
            end
            tick();
            if (nhs == 255 && !chk255) begin
                chk255 = 1'b1;
                check("t4_ops_done_255", ops_done, 255);
            end
        end
        check("t4_accepts", nacc, 256);
        check("t4_handshakes", nhs, 256);
        check("t4_bad_spacing", bad_space, 0);
        check("t4_bad_rsp", bad_rsp, 0);
        check("t4_ops_done_wrap", ops_done, 0);
        check("t4_busy_end", busy, 0);

        // 8 + 8 + 0: zero result with carry
        cmd_valid = 1'b1;
        cmd_a     = 4'h8;
        cmd_b     = 4'h8;
        cmd_cin   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_rsp_valid", rsp_valid, 1);
        check("t5_rsp_o", rsp_o, 4'h0);
        check("t5_rsp_cout", rsp_cout, 1);
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
        check("t5_rsp_zero", rsp_zero, 1);
`endif
        tick();
        check("t5_ops_done", ops_done, 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
